water_row_sequencer: RTL
========================

Name: water_row_sequencer

Overview:
- Sequences the water bitmap ROM (6-bit address, 590-bit row, registered address, row data valid the cycle after address capture).
- Each frame, on a vsync pulse, streams the 5 rows of the current animation phase to the display writer over a valid/ready handshake.
- Advances the animation phase (0→1→2→0) every PHASE_FRAMES frames.
- Sits between the frame timing generator and the row writer.

Parameters:
- PHASE_FRAMES, 8, vsync pulses per animation phase (≥1).
- NUM_PHASES, 3, number of animation phases (≤4).
- NUM_ROWS, 5, rows per phase (≤8).
- ROW_W, 590, bitmap row width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  1 = accept vsync and advance phases; 0 = freeze.
- vsync  in  1  single-cycle frame-start pulse.
- rom_en  out  1  ROM enable.
- rom_addr  out  6  ROM address = {1'b0, phase[1:0], row[2:0]}.
- rom_bitmap  in  ROW_W  ROM row data.
- out_row  out  ROW_W  captured row.
- out_row_idx  out  3  index of out_row (0..NUM_ROWS-1).
- out_phase  out  2  phase of the current burst.
- out_valid  out  1  out_row valid.
- out_ready  in  1  writer accepts row.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse after the last row is accepted.
- overrun  out  1  one-cycle pulse when vsync arrives while busy.

Behaviour:
- Reset (async assert, sync release) values: state IDLE; all outputs 0; phase, frame counter and row counter 0.
- FSM states: IDLE, ADDR, WAIT, HOLD.
- IDLE → ADDR on run & vsync.
  - Latch phase_lat = current phase.
  - Set row = 0.
  - busy = 1 from ADDR until return to IDLE.
- ADDR (1 cycle):
  - rom_en = 1, rom_addr = {0, phase_lat, row}.
  - Next state WAIT.
- WAIT (1 cycle):
  - rom_en stays 1 and rom_addr is held (the ROM output only updates while enabled).
  - At the end of WAIT: out_row ← rom_bitmap, out_row_idx ← row, out_phase ← phase_lat.
  - Next state HOLD.
- HOLD:
  - out_valid = 1; rom_en = 0.
  - out_row, out_row_idx and out_phase are stable until the handshake.
  - On out_valid & out_ready:
    - if row == NUM_ROWS-1, go to IDLE and pulse done in the next cycle (the first IDLE cycle);
    - otherwise row++ and go to ADDR.
  - No ready: hold indefinitely.
- Latency:
  - vsync high in cycle N → out_valid high in cycle N+3.
  - With out_ready tied 1, rows are spaced 3 cycles apart; a burst takes 3·NUM_ROWS cycles.
- rom_addr is 0 outside ADDR/WAIT. Phase 0 uses addresses 0..4, phase 1 uses 8..12, phase 2 uses 16..20.
- Phase timing, on every vsync with run = 1 (busy or not):
  - frame_cnt increments.
  - When frame_cnt == PHASE_FRAMES-1: frame_cnt → 0 and phase → (phase+1) mod NUM_PHASES.
  - PHASE_FRAMES = 1 advances the phase every vsync.
- vsync while busy: counted for phase timing, does not start a new burst, pulses overrun in the next cycle. The in-flight burst keeps phase_lat.
- vsync in the same cycle as the final handshake: counts as busy → overrun; no new burst.
- run = 0: vsync is ignored (no count, no burst, no overrun); an in-flight burst still completes.
- rst_n asserted mid-burst: immediate return to reset values; no done pulse. out_valid drops asynchronously.
- Phase value: phase is 2 bits and never reaches NUM_PHASES.

Test Plan:
- Reset, then run = 1, out_ready = 1, one vsync → rom_addr sequence 0,1,2,3,4 (each held 2 cycles); out_valid rises 3 cycles after vsync; out_row_idx 0..4 with out_row equal to the ROM rows; done pulses once; busy lasts 15 cycles.
- PHASE_FRAMES = 2, 7 spaced vsyncs → burst phases 0,0,1,1,2,2,0; addresses for bursts 3–4 are 8..12, for bursts 5–6 are 16..20.
- out_ready low for 10 cycles during HOLD of row 2 → out_row and out_row_idx = 2 stable, rom_en = 0; on ready, addressing resumes at 3.
- Second vsync issued mid-burst → overrun pulses one cycle later; no new burst starts; frame_cnt advances (verify via the phase change on the following burst).
- run = 0 with 5 vsyncs → no rom_en, no busy, phase unchanged; then set run = 0 mid-burst → the burst completes with done.
- rst_n low during WAIT of row 1 → all outputs 0 immediately; after release plus vsync, the burst restarts at phase 0, row 0.

Source files
------------

// File: rtl/water_row_sequencer.sv
// water_row_sequencer: once per frame, streams the rows of the current water
// animation phase from the bitmap ROM to the row writer over valid/ready.
// It also steps the animation phase every PHASE_FRAMES frames.
module water_row_sequencer #(
   parameter int PHASE_FRAMES = 8,
   parameter int NUM_PHASES   = 3,
   parameter int NUM_ROWS     = 5,
   parameter int ROW_W        = 590
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             vsync,
   output logic             rom_en,
   output logic [5:0]       rom_addr,
   input  logic [ROW_W-1:0] rom_bitmap,
   output logic [ROW_W-1:0] out_row,
   output logic [2:0]       out_row_idx,
   output logic [1:0]       out_phase,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic             overrun
);

   // Width of the frame counter; kept at least 1 bit so PHASE_FRAMES = 1 works
   localparam int FW = (PHASE_FRAMES > 1) ? $clog2(PHASE_FRAMES) : 1;
   localparam logic [FW-1:0] FRAME_LAST = FW'(PHASE_FRAMES - 1);
   localparam logic [1:0]    PHASE_LAST = 2'(NUM_PHASES - 1);
   localparam logic [2:0]    ROW_LAST   = 3'(NUM_ROWS - 1);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      WAIT,
      HOLD
   } state_t;

   state_t          state;
   logic [1:0]      phase;
   logic [1:0]      phase_lat;
   logic [FW-1:0]   frame_cnt;
   logic [2:0]      row;
   logic            frame_tick;

   // A frame only counts while the sequencer is running
   assign frame_tick = run & vsync;

   // Frame counter and animation phase, stepped on every counted vsync whether or not a burst is in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         phase     <= '0;
      end else if (frame_tick) begin
         if (frame_cnt == FRAME_LAST) begin
            frame_cnt <= '0;
            phase     <= (phase == PHASE_LAST) ? 2'd0 : phase + 2'd1;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   // Burst FSM: address the ROM, wait out its registered read, then hold the row until the writer takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         phase_lat   <= '0;
         row         <= '0;
         rom_en      <= 1'b0;
         rom_addr    <= '0;
         out_row     <= '0;
         out_row_idx <= '0;
         out_phase   <= '0;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         done    <= 1'b0;
         overrun <= frame_tick && (state != IDLE);
         case (state)
            IDLE: begin
               if (frame_tick) begin
                  state     <= ADDR;
                  phase_lat <= phase;
                  row       <= 3'd0;
                  busy      <= 1'b1;
                  rom_en    <= 1'b1;
                  rom_addr  <= {1'b0, phase, 3'd0};
               end
            end
            ADDR: begin
               state <= WAIT;
            end
            WAIT: begin
               out_row     <= rom_bitmap;
               out_row_idx <= row;
               out_phase   <= phase_lat;
               out_valid   <= 1'b1;
               rom_en      <= 1'b0;
               rom_addr    <= '0;
               state       <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (row == ROW_LAST) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     row      <= row + 3'd1;
                     state    <= ADDR;
                     rom_en   <= 1'b1;
                     rom_addr <= {1'b0, phase_lat, row + 3'd1};
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
